// File: rtl/seq_det_rr_sched_if.sv
// rtl/seq_det_rr_sched_if.sv - client and detector signal bundle for the round-robin detector scheduler
interface seq_det_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   det_rst;
    logic                   det_x;
    logic                   det_z;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_cnt;

    modport slave (
        input  req, data, det_z,
        output gnt, busy, det_rst, det_x, done, done_id, match_cnt
    );

    modport master (
        output req, data, det_z,
        input  gnt, busy, det_rst, det_x, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_det_rr_sched.sv
// rtl/seq_det_rr_sched.sv - round-robin scheduler feeding words serially into a shared "011" detector
module seq_det_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    seq_det_rr_sched_if.slave bus
);
    localparam int BI_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BI_W-1:0]    bidx_q, bidx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               det_rst_q, det_rst_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               found;
    logic [ID_W-1:0]    win;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        gnt_d       = '0;
        det_rst_d   = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        found       = 1'b0;
        win         = '0;

        // First set request at or after the pointer wins, wrapping modulo N_REQ
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    shreg_d = bus.data[int'(win)*WIDTH +: WIDTH];
                    id_d    = win;
                    ptr_d   = ID_W'((int'(win) + 1) % N_REQ);
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                bidx_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (bus.det_z && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                bidx_d = bidx_q + BI_W'(1);
                if (bidx_q == BI_W'(WIDTH - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                // Moore output lags one cycle, so the hit on the final bit shows up here
                if (bus.det_z && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with it
        if (state_d == CLR) begin
            gnt_d[id_d] = 1'b1;
            det_rst_d   = 1'b1;
        end
        if (state_d == DONE) begin
            done_d      = 1'b1;
            done_id_d   = id_d;
            match_cnt_d = cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bidx_q      <= '0;
            gnt_q       <= '0;
            det_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            gnt_q       <= gnt_d;
            det_rst_q   <= det_rst_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.det_rst   = det_rst_q;
    assign bus.det_x     = (state_q == SHIFT) && shreg_q[WIDTH-1];
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_det_rr_sched.sv
// tb/tb_seq_det_rr_sched.sv - directed bench for seq_det_rr_sched with a behavioural "011" detector
module tb_seq_det_rr_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   last_wait = 0;
    logic [7:0] dw [4];
    logic [1:0] det_s;

    seq_det_rr_sched_if #(.N_REQ(4), .WIDTH(8), .CNT_W(4), .ID_W(2)) bus ();

    seq_det_rr_sched #(.N_REQ(4), .WIDTH(8), .CNT_W(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.data = {dw[3], dw[2], dw[1], dw[0]};

    // Shared detector: 0 = start, 1 = seen 0, 2 = seen 01, 3 = seen 011 (output high)
    always_ff @(posedge clk or posedge bus.det_rst) begin
        if (bus.det_rst) det_s <= 2'd0;
        else if (!bus.det_x) det_s <= 2'd1;
        else case (det_s)
            2'd1:    det_s <= 2'd2;
            2'd2:    det_s <= 2'd3;
            default: det_s <= 2'd0;
        endcase
    end
    assign bus.det_z = (det_s == 2'd3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a grant, checks it and the whole job timeline, leaves at G+11 (negedge)
    task automatic run_job(input int exp_id, input int exp_cnt);
        int n;
        n = 0;
        while (bus.gnt == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk("gnt", 32'(bus.gnt), 32'(1) << exp_id);
        chk("det_rst_in_clr", 32'(bus.det_rst), 32'd1);
        chk("busy_in_clr", 32'(bus.busy), 32'd1);
        bus.req[exp_id] = 1'b0;
        repeat (9) @(negedge clk);
        chk("done_early", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("done", 32'(bus.done), 32'd1);
        chk("done_id", 32'(bus.done_id), 32'(exp_id));
        chk("match_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
        @(negedge clk);
        chk("done_pulse_end", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("cnt_held", 32'(bus.match_cnt), 32'(exp_cnt));
    endtask

    initial begin
        bus.req = '0;
        dw[0] = 8'b0110_0110;
        dw[1] = 8'b1111_1011;
        dw[2] = 8'b0111_0111;
        dw[3] = 8'b0000_0000;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_det_rst", 32'(bus.det_rst), 32'd1);
        chk("rst_det_x", 32'(bus.det_x), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_done_id", 32'(bus.done_id), 32'd0);
        chk("rst_match_cnt", 32'(bus.match_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("det_rst_release", 32'(bus.det_rst), 32'd0);

        // All four requesting: served 0,1,2,3 back to back, each G+12 after the previous
        bus.req = 4'b1111;
        run_job(0, 2);
        run_job(1, 1);
        chk("gap_1", 32'(last_wait), 32'd1);
        run_job(2, 2);
        chk("gap_2", 32'(last_wait), 32'd1);
        run_job(3, 0);
        chk("gap_3", 32'(last_wait), 32'd1);

        bus.req = 4'b0001;
        run_job(0, 2);

        bus.req = 4'b0010;
        run_job(1, 1);
        dw[1] = 8'hFF;
        bus.req = 4'b0010;
        run_job(1, 0);
        dw[1] = 8'h00;
        bus.req = 4'b0010;
        run_job(1, 0);

        bus.req = 4'b0100;
        run_job(2, 2);
        dw[2] = 8'b0110_1101;
        bus.req = 4'b0100;
        run_job(2, 2);

        dw[1] = 8'b1111_1011;
        bus.req = 4'b0010;
        run_job(1, 1);
        bus.req = 4'b1011;
        run_job(3, 0);
        run_job(0, 2);
        run_job(1, 1);

        // Abort a job with reset at G+4, then the held request gets a fresh grant
        bus.req = 4'b0001;
        begin : wait_g
            int n;
            n = 0;
            while (bus.gnt == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("abort_gnt", 32'(bus.gnt), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_det_rst", 32'(bus.det_rst), 32'd1);
        chk("abort_match_cnt", 32'(bus.match_cnt), 32'd0);
        chk("abort_gnt_clr", 32'(bus.gnt), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        run_job(0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
